// File: rtl/io_out_serial_arb_pkg.sv
// Shared constants and width helpers for the round-robin serial pad arbiter.
package io_out_serial_arb_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic IDLE_LVL_DEF = 1'b1;

    // Counter width that stays at least one bit when the range collapses to a single value.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/io_out_serial_arb_if.sv
// Requester-side bus of the serial pad arbiter: requests, words, grant status, pad data.
interface io_out_serial_arb_if
    import io_out_serial_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
);
    logic [N_REQ-1:0]        REQ;
    logic [N_REQ*WIDTH-1:0]  DATA;
    logic [N_REQ-1:0]        ACK;
    logic [cnt_w(N_REQ)-1:0] GRANT_ID;
    logic                    BUSY;
    logic                    OQI;

    modport master (output REQ, DATA, input ACK, GRANT_ID, BUSY, OQI);
    modport slave  (input REQ, DATA, output ACK, GRANT_ID, BUSY, OQI);
endinterface

// File: rtl/io_out_serial_arb_rr_arbiter.sv
// Combinational round-robin pick: first set request scanning upward from ptr+1, wrapping.
module rr_arbiter
    import io_out_serial_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]        req,
    input  logic [cnt_w(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]        gnt,
    output logic [cnt_w(N_REQ)-1:0] idx,
    output logic                    any
);
    localparam int IW = cnt_w(N_REQ);

    logic [IW-1:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            cand = IW'((32'(ptr) + off) % N_REQ);
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end
endmodule

// File: rtl/io_out_serial_arb.sv
// Round-robin grant of one output-register pad to N_REQ requesters, serialising the
// granted word LSB-first with start/stop framing.
module io_out_serial_arb
    import io_out_serial_arb_pkg::*;
#(
    parameter int   N_REQ    = 4,
    parameter int   WIDTH    = 8,
    parameter int   DIV      = 1,
    parameter int   GAP_BITS = 1,
    parameter logic IDLE_LVL = IDLE_LVL_DEF
) (
    input  logic               IQC,
    input  logic               QRT,
    io_out_serial_arb_if.slave bus
);
    localparam int IW = cnt_w(N_REQ);
    localparam int DW = cnt_w(DIV);
    localparam int BW = $clog2(WIDTH + 1);
    localparam int GW = cnt_w(GAP_BITS);

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_BITS - 1);
    localparam logic [IW-1:0] PTR_RST  = IW'(N_REQ - 1);

    logic [1:0]       state_q, state_d;
    logic [DW-1:0]    div_q, div_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic [IW-1:0]    grant_id_q, grant_id_d;
    logic             busy_q, busy_d;
    logic             oqi_q, oqi_d;

    logic [N_REQ-1:0] arb_gnt;
    logic [IW-1:0]    arb_idx;
    logic             arb_any;
    logic             div_end;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req (bus.REQ),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign div_end = (div_q == DIV_LAST);

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        gap_d      = gap_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        ack_d      = '0;
        grant_id_d = grant_id_q;
        case (state_q)
            S_IDLE: begin
                if (arb_any) begin
                    state_d    = S_START;
                    div_d      = '0;
                    shift_d    = bus.DATA[int'(arb_idx)*WIDTH +: WIDTH];
                    ack_d      = arb_gnt;
                    grant_id_d = arb_idx;
                    ptr_d      = arb_idx;
                end
            end
            S_START: begin
                if (div_end) begin
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            S_DATA: begin
                if (div_end) begin
                    div_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        state_d = S_STOP;
                        gap_d   = '0;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            default: begin
                if (div_end) begin
                    div_d = '0;
                    if (gap_q == GAP_LAST) state_d = S_IDLE;
                    else                   gap_d   = gap_q + GW'(1);
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
        endcase

        // Pad level is registered from the next state so it lines up with the FSM cycle.
        busy_d = (state_d != S_IDLE);
        case (state_d)
            S_START: oqi_d = ~IDLE_LVL;
            S_DATA:  oqi_d = shift_d[0];
            default: oqi_d = IDLE_LVL;
        endcase
    end

    always_ff @(posedge IQC) begin
        if (!QRT) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            gap_q      <= '0;
            shift_q    <= '0;
            ptr_q      <= PTR_RST;
            ack_q      <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            oqi_q      <= IDLE_LVL;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            gap_q      <= gap_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            ack_q      <= ack_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
            oqi_q      <= oqi_d;
        end
    end

    assign bus.ACK      = ack_q;
    assign bus.GRANT_ID = grant_id_q;
    assign bus.BUSY     = busy_q;
    assign bus.OQI      = oqi_q;
endmodule
